// File: rtl/microwave_timer_entry.sv
// microwave_timer_entry: keypad-loaded MM:SS countdown timer.
// Digits are shifted in from the right while idle, then decremented once per
// tick with BCD borrow; the value saturates at 00:00 and pulses done there.
// Ports:
//   clock                 system clock, rising edge
//   clear                 synchronous active-low reset
//   digit_valid, digit    keypad strobe and BCD digit (0-9 legal)
//   start, stop           begin/resume, pause/cancel levels
//   tick                  1 Hz enable pulse
//   min_tens..sec_units   registered BCD digits
//   running               high while counting
//   done                  one-cycle pulse when 00:00 is reached
//   zero                  high when all digits are 0
module microwave_timer_entry (
  input  logic       clock,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       done,
  output logic       zero
);

  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mt_d, mu_d, st_d, su_d;
  logic [DW-1:0] dec_mt_c, dec_mu_c, dec_st_c, dec_su_c;
  logic          done_d;
  logic          cur_zero_c;
  logic          nxt_zero_c;
  logic          dec_zero_c;
  logic          digit_ok_c;

  assign cur_zero_c = (min_tens == '0) && (min_units == '0) &&
                      (sec_tens == '0) && (sec_units == '0);
  assign dec_zero_c = (dec_mt_c == '0) && (dec_mu_c == '0) &&
                      (dec_st_c == '0) && (dec_su_c == '0);
  assign nxt_zero_c = (mt_d == '0) && (mu_d == '0) &&
                      (st_d == '0) && (su_d == '0);
  assign digit_ok_c = (digit <= DW'(9));

  // One-second decrement with BCD borrow; seconds tens borrows back to 5.
  always_comb begin
    dec_mt_c = min_tens;
    dec_mu_c = min_units;
    dec_st_c = sec_tens;
    dec_su_c = sec_units;
    if (sec_units != '0) begin
      dec_su_c = sec_units - DW'(1);
    end else begin
      dec_su_c = DW'(9);
      if (sec_tens != '0) begin
        dec_st_c = sec_tens - DW'(1);
      end else begin
        dec_st_c = DW'(5);
        if (min_units != '0) begin
          dec_mu_c = min_units - DW'(1);
        end else begin
          dec_mu_c = DW'(9);
          dec_mt_c = min_tens - DW'(1);
        end
      end
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d = state_q;
    mt_d    = min_tens;
    mu_d    = min_units;
    st_d    = sec_tens;
    su_d    = sec_units;
    done_d  = 1'b0;
    case (state_q)
      ENTRY: begin
        if (stop) begin
          mt_d = '0;
          mu_d = '0;
          st_d = '0;
          su_d = '0;
        end else if (start) begin
          // start always swallows a coincident digit, even when refused at 00:00
          if (!cur_zero_c) state_d = RUN;
        end else if (digit_valid && digit_ok_c) begin
          mt_d = min_units;
          mu_d = sec_tens;
          st_d = sec_units;
          su_d = digit;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSED;
        end else if (tick && !cur_zero_c) begin
          mt_d = dec_mt_c;
          mu_d = dec_mu_c;
          st_d = dec_st_c;
          su_d = dec_su_c;
          if (dec_zero_c) begin
            state_d = ENTRY;
            done_d  = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (stop) begin
          state_d = ENTRY;
          mt_d    = '0;
          mu_d    = '0;
          st_d    = '0;
          su_d    = '0;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  // State and output registers; running and zero are registered decodes.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= ENTRY;
      min_tens  <= '0;
      min_units <= '0;
      sec_tens  <= '0;
      sec_units <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      zero      <= 1'b1;
    end else begin
      state_q   <= state_d;
      min_tens  <= mt_d;
      min_units <= mu_d;
      sec_tens  <= st_d;
      sec_units <= su_d;
      running   <= (state_d == RUN);
      done      <= done_d;
      zero      <= nxt_zero_c;
    end
  end

endmodule

// File: tb/tb_microwave_timer_entry.sv
// Bench for microwave_timer_entry: directed scenarios plus randomized traffic
// checked against a minutes/seconds arithmetic model.
module tb_microwave_timer_entry;

  logic       clock;
  logic       clear;
  logic       digit_valid;
  logic [3:0] digit;
  logic       start;
  logic       stop;
  logic       tick;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       running, done, zero;

  int assertions = 0;
  int failures   = 0;

  // Model: mode 0 idle/entry, 1 counting, 2 paused; value as minutes+seconds.
  int m_mode = 0;
  int m_mins = 0;
  int m_secs = 0;
  int m_done = 0;

  microwave_timer_entry dut (
    .clock(clock), .clear(clear), .digit_valid(digit_valid), .digit(digit),
    .start(start), .stop(stop), .tick(tick),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
    .sec_units(sec_units), .running(running), .done(done), .zero(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [18:0] observed();
    return {min_tens, min_units, sec_tens, sec_units, running, done, zero};
  endfunction

  function automatic logic [18:0] model_exp();
    logic r, d, z;
    r = (m_mode == 1);
    d = (m_done != 0);
    z = (m_mins == 0) && (m_secs == 0);
    return {4'(m_mins / 10), 4'(m_mins % 10), 4'(m_secs / 10), 4'(m_secs % 10), r, d, z};
  endfunction

  task automatic model_step(input logic c, dv, input logic [3:0] d, input logic s, p, t);
    int v;
    m_done = 0;
    if (!c) begin
      m_mode = 0; m_mins = 0; m_secs = 0;
    end else if (m_mode == 0) begin
      if (p) begin
        m_mins = 0; m_secs = 0;
      end else if (s) begin
        if (m_mins + m_secs != 0) m_mode = 1;
      end else if (dv && d <= 4'd9) begin
        v = ((m_mins * 100 + m_secs) * 10 + int'(d)) % 10000;
        m_mins = v / 100;
        m_secs = v % 100;
      end
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else if (t) begin
        if (m_secs > 0) m_secs = m_secs - 1;
        else if (m_mins > 0) begin m_mins = m_mins - 1; m_secs = 59; end
        if (m_mins == 0 && m_secs == 0) begin m_mode = 0; m_done = 1; end
      end
    end else begin
      if (p) begin m_mode = 0; m_mins = 0; m_secs = 0; end
      else if (s) m_mode = 1;
    end
  endtask

  task automatic drive(input logic c, dv, input logic [3:0] d, input logic s, p, t);
    clear = c; digit_valid = dv; digit = d; start = s; stop = p; tick = t;
    @(posedge clock);
    #1;
    model_step(c, dv, d, s, p, t);
    clear = 1'b1; digit_valid = 1'b0; digit = 4'd0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);   drive(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic press_start();               drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic press_stop();                drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); endtask
  task automatic one_tick();                  drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle();                      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); endtask
  task automatic cancel();                    press_stop(); press_stop(); endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL reset_state got %h want %h", observed(), {16'h0000, 3'b001});
    end
    key(4'd1); key(4'd3); key(4'd0);
    assertions++;
    if (observed() !== {16'h0130, 3'b000}) begin
      failures++;
      $display("FAIL entry_0130 got %h want %h", observed(), {16'h0130, 3'b000});
    end
  endtask

  task automatic test_borrow();
    cancel();
    key(4'd1); key(4'd0); key(4'd0); press_start(); one_tick();
    assertions++;
    if (observed() !== {16'h0059, 3'b100}) begin
      failures++;
      $display("FAIL borrow_0100 got %h want %h", observed(), {16'h0059, 3'b100});
    end
    cancel();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); press_start(); one_tick();
    assertions++;
    if (observed() !== {16'h0959, 3'b100}) begin
      failures++;
      $display("FAIL borrow_1000 got %h want %h", observed(), {16'h0959, 3'b100});
    end
    cancel();
  endtask

  task automatic test_end();
    key(4'd3);
    press_start();
    assertions++;
    if (observed() !== {16'h0003, 3'b100}) begin
      failures++;
      $display("FAIL end_started got %h want %h", observed(), {16'h0003, 3'b100});
    end
    one_tick(); one_tick(); one_tick();
    assertions++;
    if (observed() !== {16'h0000, 3'b011}) begin
      failures++;
      $display("FAIL end_done got %h want %h", observed(), {16'h0000, 3'b011});
    end
    idle();
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL end_done_drop got %h want %h", observed(), {16'h0000, 3'b001});
    end
    for (int i = 0; i < 2; i++) begin
      one_tick();
      assertions++;
      if (observed() !== {16'h0000, 3'b001}) begin
        failures++;
        $display("FAIL end_saturate%0d got %h want %h", i, observed(), {16'h0000, 3'b001});
      end
    end
  endtask

  task automatic test_pause();
    key(4'd1); key(4'd0); press_start(); one_tick(); one_tick();
    assertions++;
    if (observed() !== {16'h0008, 3'b100}) begin
      failures++;
      $display("FAIL pause_run got %h want %h", observed(), {16'h0008, 3'b100});
    end
    press_stop(); one_tick(); one_tick(); one_tick();
    assertions++;
    if (observed() !== {16'h0008, 3'b000}) begin
      failures++;
      $display("FAIL pause_hold got %h want %h", observed(), {16'h0008, 3'b000});
    end
    press_start(); one_tick();
    assertions++;
    if (observed() !== {16'h0007, 3'b100}) begin
      failures++;
      $display("FAIL pause_resume got %h want %h", observed(), {16'h0007, 3'b100});
    end
    press_stop(); press_stop();
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL pause_cancel got %h want %h", observed(), {16'h0000, 3'b001});
    end
    key(4'd2);
    assertions++;
    if (observed() !== {16'h0002, 3'b000}) begin
      failures++;
      $display("FAIL pause_entry_after got %h want %h", observed(), {16'h0002, 3'b000});
    end
    press_stop();
  endtask

  task automatic test_coincident();
    press_start();
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL start_at_zero got %h want %h", observed(), {16'h0000, 3'b001});
    end
    key(4'd5);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL start_stop_entry got %h want %h", observed(), {16'h0000, 3'b001});
    end
    key(4'd5); key(4'hC);
    assertions++;
    if (observed() !== {16'h0005, 3'b000}) begin
      failures++;
      $display("FAIL illegal_digit got %h want %h", observed(), {16'h0005, 3'b000});
    end
    drive(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1);
    assertions++;
    if (observed() !== {16'h0005, 3'b100}) begin
      failures++;
      $display("FAIL start_over_digit got %h want %h", observed(), {16'h0005, 3'b100});
    end
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    assertions++;
    if (observed() !== {16'h0005, 3'b000}) begin
      failures++;
      $display("FAIL tick_stop_run got %h want %h", observed(), {16'h0005, 3'b000});
    end
    key(4'd9); one_tick();
    assertions++;
    if (observed() !== {16'h0005, 3'b000}) begin
      failures++;
      $display("FAIL paused_ignores got %h want %h", observed(), {16'h0005, 3'b000});
    end
    press_stop();
  endtask

  task automatic test_reset_mid_run();
    key(4'd4); key(4'd0); press_start(); one_tick();
    assertions++;
    if (observed() !== {16'h0039, 3'b100}) begin
      failures++;
      $display("FAIL mid_run_pre got %h want %h", observed(), {16'h0039, 3'b100});
    end
    drive(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1);
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL mid_run_reset got %h want %h", observed(), {16'h0000, 3'b001});
    end
    one_tick();
    assertions++;
    if (observed() !== {16'h0000, 3'b001}) begin
      failures++;
      $display("FAIL mid_run_after got %h want %h", observed(), {16'h0000, 3'b001});
    end
  endtask

  task automatic test_random();
    logic c, dv, s, p, t;
    logic [3:0] d;
    for (int i = 0; i < 3000; i++) begin
      c  = ($urandom_range(0, 299) != 0);
      dv = ($urandom_range(0, 2) == 0);
      d  = 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 2) == 0);
      drive(c, dv, d, s, p, t);
      assertions++;
      if (observed() !== model_exp()) begin
        failures++;
        $display("FAIL random_cycle%0d got %h want %h", i, observed(), model_exp());
      end
    end
  endtask

  initial begin
    clear = 1'b1; digit_valid = 1'b0; digit = 4'd0;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    test_reset();
    test_borrow();
    test_end();
    test_pause();
    test_coincident();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/microwave_timer_entry.md
# microwave_timer_entry

Keypad-driven MM:SS countdown timer for the timer-and-control input path. It captures BCD digits from the keypad by shifting them in from the right, then counts down once per `tick` after `start`. At 00:00 it saturates instead of wrapping, matching the non-recycling behaviour the rest of the timer path relies on. It is the loading and driving side of the countdown: it produces the digit values, `running` and `done` consumed by the display and magnetron control blocks.

## Interface
Parameters: none.

Ports:
- `clock` input 1: system clock; all state updates on the rising edge.
- `clear` input 1: reset, synchronous, active-low.
- `digit_valid` input 1: one-cycle strobe; `digit` is valid this cycle.
- `digit` input 4: BCD keypad digit; only 0–9 are legal.
- `start` input 1: level sampled each cycle; begin or resume the countdown.
- `stop` input 1: level sampled each cycle; pause, or cancel when already paused.
- `tick` input 1: one-cycle 1 Hz enable pulse from the prescaler.
- `min_tens` output 4: BCD minutes tens digit.
- `min_units` output 4: BCD minutes units digit.
- `sec_tens` output 4: BCD seconds tens digit.
- `sec_units` output 4: BCD seconds units digit.
- `running` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when the countdown reaches 00:00.
- `zero` output 1: high when all four digits are 0.

## Operation
- States: ENTRY, RUN, PAUSED.
- Reset (`clear`=0 at a clock edge) puts the block in ENTRY with all digits 0, `running`=0, `done`=0 and `zero`=1. Reset overrides every other input, including mid-countdown.
- ENTRY, digit entry:
  - `digit_valid` with `digit`≤9 shifts the digits left: `min_tens`←`min_units`, `min_units`←`sec_tens`, `sec_tens`←`sec_units`, `sec_units`←`digit`.
  - The old `min_tens` is discarded.
  - `digit`>9 is ignored.
- ENTRY, other inputs:
  - `start` with a nonzero value moves to RUN.
  - `start` with the value 00:00 is ignored.
  - `stop` clears all digits to 0.
  - `tick` is ignored.
- RUN:
  - `tick` decrements the value by one second with BCD borrow.
  - `sec_units` 0→9 borrows from `sec_tens`; `sec_tens` 0→5 borrows from `min_units`; `min_units` 0→9 borrows from `min_tens`.
  - `sec_tens` values entered above 5 (e.g. 0:75) count down normally from their entered value.
  - `digit_valid` and `start` are ignored.
  - `stop` moves to PAUSED with the value held.
- Reaching 00:00: the decrement that produces 00:00 also returns the block to ENTRY and pulses `done`. The value never wraps below 00:00.
- PAUSED:
  - `start` returns to RUN.
  - `stop` clears all digits to 0 and returns to ENTRY.
  - `tick` and `digit_valid` are ignored.
- Priorities when inputs coincide in the same cycle:
  - `stop` over `start`.
  - `stop` over `tick`; the tick is lost and there is no decrement.
  - `start` over `digit_valid`; the digit is discarded.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `start` sampled at edge N (state ENTRY or PAUSED, start conditions met): `running`=1 from edge N.
- First decrement: the first `tick` sampled at an edge after N; a `tick` coincident with the `start` edge is not counted.
- Decrement: the digit outputs update at the same edge that samples `tick`.
- Final tick: the edge that produces 00:00 also sets `running`=0, `zero`=1 and `done`=1. `done` returns to 0 at the next edge.
- `stop` in RUN: `running`=0 from the sampling edge.
- Total run length: an entered value of S seconds ends exactly S ticks after entering RUN.
- `zero` tracks the registered digits. It may also be produced as a registered compare, provided it is valid in the same cycle as the digits.

## Test plan
- Reset then entry: hold `clear`=0 for 2 cycles, release, then strobe digits 1,3,0 → outputs 0,1,3,0 (01:30), `zero`=0, `running`=0.
- Borrow chain: enter 1,0,0 (01:00), `start`, 1 `tick` → 00:59. Enter 1,0,0,0 (10:00), `start`, 1 `tick` → 09:59.
- Non-recycling end: enter 0:03, `start`, 5 ticks.
  - After tick 3: 00:00, `done` high for exactly 1 cycle, `running`=0.
  - Ticks 4 and 5: the value stays 00:00 and `done` stays 0.
- Pause, resume, cancel: 00:10 running, 2 ticks → 00:08.
  - `stop`, then 3 ticks → still 00:08.
  - `start`, 1 tick → 00:07.
  - `stop`, `stop` → 00:00, state ENTRY.
- Coincident and illegal inputs:
  - `start` with value 00:00 → `running` stays 0.
  - `start`+`stop` in the same cycle in ENTRY with 00:05 → value cleared to 00:00, `running`=0.
  - `digit`=4'hC strobed → no change.
  - `tick`+`stop` in RUN at 00:05 → PAUSED at 00:05.
- Reset mid-run: 00:40 running, pull `clear`=0 for 1 cycle → all digits 0, `running`=0, `done`=0, state ENTRY.
